// File: rtl/popcount_unit.sv
// popcount_unit: registered population counter built as a balanced binary
// adder tree. Optional extra register stages are placed between tree levels,
// starting nearest the output, so wide inputs can meet timing. Latency is
// 1 + PIPE_STAGES cycles with one independent result per cycle.
module popcount_unit #(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 4,
    parameter int PIPE_STAGES    = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_IN_WIDTH-1:0]  io_in,
    output logic [DATA_OUT_WIDTH-1:0] io_out
);

    // Number of adder levels between the single-bit leaves and the final sum.
    localparam int LEVELS = $clog2(DATA_IN_WIDTH);
    // Guarded divisor so the stage placement arithmetic never divides by zero.
    localparam int STAGE_DIV = (PIPE_STAGES > 0) ? PIPE_STAGES : 1;

    // Operand count at a given tree level: each level halves it, rounding up
    // because an odd leftover operand is carried through unchanged.
    function automatic int node_count(input int lvl);
        return (DATA_IN_WIDTH + (1 << lvl) - 1) >> lvl;
    endfunction

    // Extra stage k sits after level LEVELS-1-floor(k*LEVELS/PIPE_STAGES).
    // Stage 0 lands just below the output register and the rest step down the
    // tree at an even spacing; level 0 means the leaves themselves are held.
    function automatic bit stage_has_reg(input int lvl);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            if (lvl < LEVELS && (LEVELS - 1 - (k * LEVELS) / STAGE_DIV) == lvl) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Parameter sanity: refuse to elaborate a configuration that cannot hold
    // the full count or that asks for more stages than there are tree levels.
    if (DATA_IN_WIDTH < 1) begin : g_in_width_check
        $error("popcount_unit: DATA_IN_WIDTH must be at least 1");
    end
    if (DATA_OUT_WIDTH < $clog2(DATA_IN_WIDTH + 1)) begin : g_out_width_check
        $error("popcount_unit: DATA_OUT_WIDTH too small to hold DATA_IN_WIDTH");
    end
    if (PIPE_STAGES < 0 || PIPE_STAGES > LEVELS) begin : g_stage_check
        $error("popcount_unit: PIPE_STAGES must be within 0..clog2(DATA_IN_WIDTH)");
    end

    // Every node is carried at the full output width; the bits above the
    // natural width of a level simply stay zero, so no sum can overflow.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = node_count(l);
        logic [DATA_OUT_WIDTH-1:0] sum_v [CNT];
        logic [DATA_OUT_WIDTH-1:0] out_v [CNT];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < CNT; i++) begin : g_node
                assign sum_v[i] = DATA_OUT_WIDTH'(io_in[i]);
            end
        end else begin : g_add
            localparam int PCNT = node_count(l - 1);
            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2 * i + 1 < PCNT) begin : g_pair
                    assign sum_v[i] = g_lvl[l-1].out_v[2*i] + g_lvl[l-1].out_v[2*i+1];
                end else begin : g_pass
                    assign sum_v[i] = g_lvl[l-1].out_v[2*i];
                end
            end
        end

        if (stage_has_reg(l)) begin : g_reg
            // Optional pipeline stage for this level, cleared with the output.
            always_ff @(posedge clock) begin
                for (int i = 0; i < CNT; i++) begin
                    if (reset) begin
                        out_v[i] <= '0;
                    end else begin
                        out_v[i] <= sum_v[i];
                    end
                end
            end
        end else begin : g_wire
            for (genvar i = 0; i < CNT; i++) begin : g_node
                assign out_v[i] = sum_v[i];
            end
        end
    end

    // Output register: always present, holds the root of the tree.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_out <= '0;
        end else begin
            io_out <= g_lvl[LEVELS].out_v[0];
        end
    end

endmodule

// File: tb/tb_popcount_unit.sv
// Testbench for popcount_unit: default 8-bit instance (latency 1) and a
// 32-bit instance with two extra pipeline stages (latency 3), both checked
// against a bit-counting reference model.
module tb_popcount_unit;

    logic        clock;
    logic        reset;
    logic [7:0]  narrow_in;
    logic [3:0]  narrow_out;
    logic [31:0] wide_in;
    logic [5:0]  wide_out;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [7:0] stim;
        int         expect_count;
    } vec_t;

    vec_t vectors [9];

    int wide_q [$];

    popcount_unit dut_narrow (
        .clock  (clock),
        .reset  (reset),
        .io_in  (narrow_in),
        .io_out (narrow_out)
    );

    popcount_unit #(
        .DATA_IN_WIDTH  (32),
        .DATA_OUT_WIDTH (6),
        .PIPE_STAGES    (2)
    ) dut_wide (
        .clock  (clock),
        .reset  (reset),
        .io_in  (wide_in),
        .io_out (wide_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: count the set bits one at a time.
    function automatic int ref_popcount(input logic [31:0] word);
        int n;
        n = 0;
        for (int b = 0; b < 32; b++) begin
            if (word[b] === 1'b1) n++;
        end
        return n;
    endfunction

    // Drive inputs and reset, then advance past the next rising edge.
    task automatic applyStimulus(input logic [7:0] n_val, input logic [31:0] w_val,
                                 input logic rst);
        narrow_in = n_val;
        wide_in   = w_val;
        reset     = rst;
        @(posedge clock);
        #1;
    endtask

    // Compare an observed value against the model's value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input int required);
        checks++;
        if (actual !== 32'(required)) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        narrow_in = 8'h00;
        wide_in   = 32'h0;

        vectors[0] = '{"zero",     8'h00, 0};
        vectors[1] = '{"ones",     8'hFF, 8};
        vectors[2] = '{"msb",      8'h80, 1};
        vectors[3] = '{"lsb",      8'h01, 1};
        vectors[4] = '{"pat_a5",   8'hA5, 4};
        vectors[5] = '{"pat_5a",   8'h5A, 4};
        vectors[6] = '{"pat_0f",   8'h0F, 4};
        vectors[7] = '{"pat_7f",   8'h7F, 7};
        vectors[8] = '{"pat_fe",   8'hFE, 7};

        // Reset held for three cycles with all-ones on the input.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(8'hFF, 32'hFFFF_FFFF, 1'b1);
            checkOutput("reset_narrow", 32'(narrow_out), 0);
            checkOutput("reset_wide", 32'(wide_out), 0);
        end
        applyStimulus(8'hFF, 32'h0, 1'b0);
        checkOutput("release_narrow", 32'(narrow_out), 8);

        // Table-driven corner values and patterns, one cycle latency each.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vectors[v].stim, 32'h0, 1'b0);
            checkOutput(vectors[v].name, 32'(narrow_out), vectors[v].expect_count);
        end

        // Sweep 0..254 with a one-cycle reset pulse in the middle.
        for (int v = 0; v < 255; v++) begin
            applyStimulus(8'(v), 32'h0, (v == 100) ? 1'b1 : 1'b0);
            if (v == 100) begin
                checkOutput("sweep_midreset", 32'(narrow_out), 0);
            end else begin
                checkOutput("sweep", 32'(narrow_out), ref_popcount(32'(v)));
            end
        end
        reset = 1'b0;

        // Random stimulus on the default instance.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] x;
            x = 8'($urandom_range(0, 255));
            applyStimulus(x, 32'h0, 1'b0);
            checkOutput("rand_narrow", 32'(narrow_out), ref_popcount(32'(x)));
        end

        // Wide instance: single all-ones word appears exactly three cycles later.
        applyStimulus(8'h00, 32'hFFFF_FFFF, 1'b0);
        checkOutput("wide_ones_c1", 32'(wide_out), 0);
        applyStimulus(8'h00, 32'h0, 1'b0);
        checkOutput("wide_ones_c2", 32'(wide_out), 0);
        applyStimulus(8'h00, 32'h0, 1'b0);
        checkOutput("wide_ones_c3", 32'(wide_out), 32);
        applyStimulus(8'h00, 32'h0, 1'b0);
        checkOutput("wide_ones_c4", 32'(wide_out), 0);

        // Wide instance random sweep: the two most recent inputs are still in
        // flight, both zero, so the expected queue starts with two zeros.
        wide_q.push_back(0);
        wide_q.push_back(0);
        for (int r = 0; r < 80; r++) begin
            logic [31:0] x;
            x = $urandom();
            if (r % 7 == 3) x = 32'hFFFF_FFFF;
            wide_q.push_back(ref_popcount(x));
            applyStimulus(8'h00, x, 1'b0);
            checkOutput("rand_wide", 32'(wide_out), wide_q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
